fan_ctrl: RTL and testbench

//  Closed-loop fan speed regulator between the tacho block and the pwm block.
//  - Consumes the per-second tacho count and produces an 8-bit PWM duty.
//  - Flags a stalled fan as an interrupt source for intc.
//  - Software access is through three registers on the shared 5-bit CSR bus;
//    csr_do is ORed with the other CSR blocks.

---
 rtl/fan_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_fan_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_ctrl.sv
// Closed-loop fan regulator: turns per-second tacho counts into an 8-bit PWM duty,
// with a timed spin-up, stall detection and a three-register CSR window.
module fan_ctrl #(
  parameter logic [4:0] BASE_ADDR     = 5'h0,
  parameter logic [7:0] STEP          = 8'd4,
  parameter logic [7:0] SPINUP_DUTY   = 8'hff,
  parameter logic [3:0] SPINUP_TICKS  = 4'd8,
  parameter logic [2:0] STALL_SAMPLES = 3'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       ce_8hz,
  input  logic [7:0] tacho_cnt,
  input  logic       tacho_valid,
  output logic [7:0] duty,
  output logic       stall_irq
);

  typedef enum logic [2:0] {
    S_OFF,
    S_MANUAL,
    S_SPINUP,
    S_REGULATE,
    S_STALL
  } state_t;

  localparam logic [4:0] ADDR_CTRL = BASE_ADDR;
  localparam logic [4:0] ADDR_TGT  = BASE_ADDR + 5'd1;
  localparam logic [4:0] ADDR_DUTY = BASE_ADDR + 5'd2;

  state_t     r_state;
  logic       r_en;
  logic       r_auto;
  logic       r_stall_flag;
  logic [7:0] r_target;
  logic [7:0] r_man_duty;
  logic [7:0] r_duty;
  logic       r_stall_irq;
  logic [3:0] r_ticks;
  logic [2:0] r_zero_cnt;

  logic       w_wr_ctrl;
  logic       w_wr_tgt;
  logic       w_wr_duty;
  logic       w_en;
  logic       w_auto;
  logic [7:0] w_man;
  logic       w_flag_clr;
  logic [8:0] w_up;
  logic [8:0] w_dn;
  logic [7:0] w_up_sat;
  logic [7:0] w_dn_sat;
  logic [7:0] w_reg_duty;
  logic       w_zero_hit;
  logic [2:0] w_zero_next;
  logic       w_stall_hit;

  assign w_wr_ctrl = csr_we && (csr_a == ADDR_CTRL);
  assign w_wr_tgt  = csr_we && (csr_a == ADDR_TGT);
  assign w_wr_duty = csr_we && (csr_a == ADDR_DUTY);

  // The FSM looks at the values being written this cycle so a write is visible one clk later.
  assign w_en       = w_wr_ctrl ? csr_di[0] : r_en;
  assign w_auto     = w_wr_ctrl ? csr_di[1] : r_auto;
  assign w_man      = w_wr_duty ? csr_di    : r_man_duty;
  assign w_flag_clr = w_wr_ctrl && csr_di[7];

  assign w_up       = {1'b0, r_duty} + {1'b0, STEP};
  assign w_dn       = {1'b0, r_duty} - {1'b0, STEP};
  assign w_up_sat   = w_up[8] ? 8'hff : w_up[7:0];
  assign w_dn_sat   = w_dn[8] ? 8'h00 : w_dn[7:0];
  assign w_reg_duty = (tacho_cnt < r_target) ? w_up_sat :
                      (tacho_cnt > r_target) ? w_dn_sat : r_duty;

  assign w_zero_hit  = tacho_valid && (tacho_cnt == 8'd0) && (r_duty != 8'd0);
  assign w_zero_next = r_zero_cnt + 3'd1;
  assign w_stall_hit = w_zero_hit && (w_zero_next >= STALL_SAMPLES);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    csr_do = 8'h00;
    if (csr_a == ADDR_CTRL)      csr_do = {r_stall_flag, 5'b0, r_auto, r_en};
    else if (csr_a == ADDR_TGT)  csr_do = r_target;
    else if (csr_a == ADDR_DUTY) csr_do = r_duty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_target   <= 8'h00;
      r_man_duty <= 8'h00;
    end else begin
      // NOTE: state registers use non-blocking assignments so every block samples pre-edge values.
      if (w_wr_ctrl) begin
        r_en   <= csr_di[0];
        r_auto <= csr_di[1];
      end
      if (w_wr_tgt)  r_target   <= csr_di;
      if (w_wr_duty) r_man_duty <= csr_di;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_OFF;
      r_duty       <= 8'h00;
      r_stall_irq  <= 1'b0;
      r_stall_flag <= 1'b0;
      r_ticks      <= 4'd0;
      r_zero_cnt   <= 3'd0;
    end else begin
      r_stall_irq <= 1'b0;
      if (w_flag_clr) r_stall_flag <= 1'b0;

      if (!w_en) begin
        r_state    <= S_OFF;
        r_duty     <= 8'h00;
        r_ticks    <= 4'd0;
        r_zero_cnt <= 3'd0;
      end else begin
        case (r_state)
          S_OFF, S_MANUAL: begin
            if (w_auto) begin
              r_state <= S_SPINUP;
              r_ticks <= SPINUP_TICKS;
              r_duty  <= SPINUP_DUTY;
            end else begin
              r_state <= S_MANUAL;
              r_duty  <= w_man;
            end
          end

          S_SPINUP: begin
            if (!w_auto) begin
              r_state <= S_MANUAL;
              r_duty  <= w_man;
              r_ticks <= 4'd0;
            end else begin
              r_duty <= SPINUP_DUTY;
              // Tacho samples are ignored here; the fan is not yet at speed.
              if (ce_8hz) begin
                r_ticks <= r_ticks - 4'd1;
                if (r_ticks <= 4'd1) r_state <= S_REGULATE;
              end
            end
          end

          S_REGULATE: begin
            if (!w_auto) begin
              r_state    <= S_MANUAL;
              r_duty     <= w_man;
              r_zero_cnt <= 3'd0;
            end else if (tacho_valid) begin
              if (w_stall_hit) begin
                r_state      <= S_STALL;
                r_duty       <= 8'hff;
                r_stall_flag <= 1'b1;
                r_stall_irq  <= 1'b1;
                r_zero_cnt   <= 3'd0;
              end else begin
                r_duty <= w_reg_duty;
                if (tacho_cnt != 8'd0) r_zero_cnt <= 3'd0;
                else if (w_zero_hit)   r_zero_cnt <= w_zero_next;
              end
            end
          end

          S_STALL: begin
            r_duty <= 8'hff;
            if (w_flag_clr) begin
              if (w_auto) begin
                r_state <= S_SPINUP;
                r_ticks <= SPINUP_TICKS;
                r_duty  <= SPINUP_DUTY;
              end else begin
                r_state <= S_MANUAL;
                r_duty  <= w_man;
              end
            end
          end

          default: begin
            r_state <= S_OFF;
            r_duty  <= 8'h00;
          end
        endcase
      end
    end
  end

  assign duty      = r_duty;
  assign stall_irq = r_stall_irq;

endmodule

// File: tb/tb_fan_ctrl.sv
// Self-checking bench for fan_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural reference model.
module tb_fan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic       ce_8hz;
  logic [7:0] tacho_cnt;
  logic       tacho_valid;
  logic [7:0] duty;
  logic       stall_irq;

  int n_checks = 0;
  int n_pass   = 0;

  fan_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_a       (csr_a),
    .csr_di      (csr_di),
    .csr_we      (csr_we),
    .csr_do      (csr_do),
    .ce_8hz      (ce_8hz),
    .tacho_cnt   (tacho_cnt),
    .tacho_valid (tacho_valid),
    .duty        (duty),
    .stall_irq   (stall_irq)
  );

  always #5 clk = ~clk;

  // Reference model: fan behaviour described as modes and integer arithmetic.
  localparam int M_OFF = 0, M_MANUAL = 1, M_SPIN = 2, M_REG = 3, M_STALL = 4;
  int         m_mode;
  int         m_duty;
  int         m_spin_left;
  int         m_zeros;
  bit         m_irq;
  bit         m_en;
  bit         m_auto;
  bit         m_flag;
  int         m_target;
  int         m_man;

  task automatic model_reset();
    m_mode = M_OFF; m_duty = 0; m_spin_left = 0; m_zeros = 0; m_irq = 0;
    m_en = 0; m_auto = 0; m_flag = 0; m_target = 0; m_man = 0;
  endtask

  task automatic model_step(input logic we, input logic [4:0] a, input logic [7:0] di,
                            input logic ce, input logic tv, input logic [7:0] cnt);
    bit wc, clr, entered, en, au;
    int man, c;
    wc      = we && (a == 5'd0);
    clr     = wc && di[7];
    en      = wc ? di[0] : m_en;
    au      = wc ? di[1] : m_auto;
    man     = (we && a == 5'd2) ? int'(di) : m_man;
    c       = int'(cnt);
    entered = 0;
    m_irq   = 0;
    if (!en) begin
      m_mode = M_OFF; m_duty = 0; m_zeros = 0; m_spin_left = 0;
    end else if (m_mode == M_OFF || m_mode == M_MANUAL) begin
      if (au) begin m_mode = M_SPIN; m_spin_left = 8; m_duty = 255; end
      else    begin m_mode = M_MANUAL; m_duty = man; end
    end else if (m_mode == M_SPIN) begin
      if (!au) begin m_mode = M_MANUAL; m_duty = man; m_spin_left = 0; end
      else begin
        m_duty = 255;
        if (ce) begin
          m_spin_left = m_spin_left - 1;
          if (m_spin_left == 0) m_mode = M_REG;
        end
      end
    end else if (m_mode == M_REG) begin
      if (!au) begin m_mode = M_MANUAL; m_duty = man; m_zeros = 0; end
      else if (tv) begin
        if (c != 0)          m_zeros = 0;
        else if (m_duty > 0) m_zeros = m_zeros + 1;
        if (m_zeros >= 3) begin
          m_mode = M_STALL; m_duty = 255; m_irq = 1; entered = 1; m_zeros = 0;
        end else if (c < m_target) m_duty = (m_duty + 4 > 255) ? 255 : m_duty + 4;
        else if (c > m_target)     m_duty = (m_duty - 4 < 0) ? 0 : m_duty - 4;
      end
    end else begin
      m_duty = 255;
      if (clr) begin
        if (au) begin m_mode = M_SPIN; m_spin_left = 8; end
        else    begin m_mode = M_MANUAL; m_duty = man; end
      end
    end
    if (entered)  m_flag = 1;
    else if (clr) m_flag = 0;
    m_en = en; m_auto = au; m_man = man;
    if (we && a == 5'd1) m_target = int'(di);
  endtask

  function automatic logic [7:0] model_read(input logic [4:0] a);
    case (a)
      5'd0:    return {m_flag, 5'b0, m_auto, m_en};
      5'd1:    return 8'(m_target);
      5'd2:    return 8'(m_duty);
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply(input logic we, input logic [4:0] a, input logic [7:0] di,
                       input logic ce, input logic tv, input logic [7:0] cnt);
    csr_we = we; csr_a = a; csr_di = di; ce_8hz = ce; tacho_valid = tv; tacho_cnt = cnt;
    model_step(we, a, di, ce, tv, cnt);
    @(posedge clk);
    #1;
    csr_we = 1'b0; ce_8hz = 1'b0; tacho_valid = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    check(name, 32'(csr_do), 32'(exp));
  endtask

  task automatic out_check(input string name, input logic [7:0] ed, input logic ei);
    check(name, 32'(duty), 32'(ed));
    check({name, "_irq"}, 32'(stall_irq), 32'(ei));
  endtask

  task automatic tacho(input logic [7:0] cnt);
    apply(1'b0, 5'd0, 8'h00, 1'b0, 1'b1, cnt);
  endtask

  typedef struct {
    logic       we;
    logic [4:0] a;
    logic [7:0] di;
    logic       ce;
    logic       tv;
    logic [7:0] cnt;
    logic [4:0] rd;
    logic [7:0] exp_duty;
    logic       exp_irq;
    logic [7:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [4:0] a, input logic [7:0] di,
                              input logic ce, input logic tv, input logic [7:0] cnt,
                              input logic [4:0] rd, input logic [7:0] ed, input logic ei,
                              input logic [7:0] er);
    vec_t v;
    v.we = we; v.a = a; v.di = di; v.ce = ce; v.tv = tv; v.cnt = cnt;
    v.rd = rd; v.exp_duty = ed; v.exp_irq = ei; v.exp_rd = er;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; csr_we = 1'b0; csr_a = 5'd0; csr_di = 8'h00;
    ce_8hz = 1'b0; tacho_valid = 1'b0; tacho_cnt = 8'h00;
    model_reset();

    // Manual mode, then spin-up (8 ticks, tacho ignored while spinning), then regulation.
    vecs.push_back(mk(1, 5'd0, 8'h01, 0, 0, 8'h00, 5'd0, 8'h00, 0, 8'h01));
    vecs.push_back(mk(1, 5'd2, 8'h80, 0, 0, 8'h00, 5'd2, 8'h80, 0, 8'h80));
    vecs.push_back(mk(1, 5'd0, 8'h00, 0, 0, 8'h00, 5'd0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 5'd1, 8'h20, 0, 0, 8'h00, 5'd1, 8'h00, 0, 8'h20));
    vecs.push_back(mk(1, 5'd0, 8'h03, 0, 0, 8'h00, 5'd0, 8'hff, 0, 8'h03));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 5'd0, 8'h00, 1, 0, 8'h00, 5'd0, 8'hff, 0, 8'h03));
    vecs.push_back(mk(0, 5'd0, 8'h00, 1, 1, 8'h30, 5'd2, 8'hff, 0, 8'hff));
    vecs.push_back(mk(0, 5'd0, 8'h00, 1, 1, 8'h30, 5'd2, 8'hff, 0, 8'hff));
    vecs.push_back(mk(0, 5'd0, 8'h00, 0, 1, 8'h30, 5'd2, 8'hfb, 0, 8'hfb));
    vecs.push_back(mk(0, 5'd0, 8'h00, 0, 1, 8'h30, 5'd2, 8'hf7, 0, 8'hf7));
    vecs.push_back(mk(0, 5'd0, 8'h00, 0, 1, 8'h20, 5'd2, 8'hf7, 0, 8'hf7));
    vecs.push_back(mk(0, 5'd0, 8'h00, 0, 1, 8'h10, 5'd2, 8'hfb, 0, 8'hfb));
    vecs.push_back(mk(0, 5'd0, 8'h00, 0, 1, 8'h10, 5'd2, 8'hff, 0, 8'hff));
    vecs.push_back(mk(0, 5'd0, 8'h00, 0, 1, 8'h10, 5'd2, 8'hff, 0, 8'hff));

    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_check("rst_ctrl", 5'd0, 8'h00);
    rd_check("rst_target", 5'd1, 8'h00);
    rd_check("rst_duty_reg", 5'd2, 8'h00);
    rd_check("rst_out_of_range", 5'd3, 8'h00);
    out_check("rst_out", 8'h00, 1'b0);

    foreach (vecs[i]) begin
      apply(vecs[i].we, vecs[i].a, vecs[i].di, vecs[i].ce, vecs[i].tv, vecs[i].cnt);
      out_check($sformatf("vec%0d", i), vecs[i].exp_duty, vecs[i].exp_irq);
      rd_check($sformatf("vec%0d_rd", i), vecs[i].rd, vecs[i].exp_rd);
    end

    // Ramp down to zero: 255 - 63*4 = 3, the 64th step saturates at 0 and holds.
    for (int k = 1; k <= 65; k++) begin
      tacho(8'hff);
      if (k == 63) out_check("ramp_63", 8'h03, 1'b0);
      if (k == 64) out_check("ramp_floor", 8'h00, 1'b0);
      if (k == 65) out_check("ramp_hold", 8'h00, 1'b0);
    end

    // Stall: zero samples at duty 0 do not count, a nonzero sample restarts the count.
    tacho(8'h00); out_check("stall_supp", 8'h04, 1'b0);
    tacho(8'h00); out_check("stall_z1", 8'h08, 1'b0);
    tacho(8'h00); out_check("stall_z2", 8'h0c, 1'b0);
    tacho(8'h05); out_check("stall_clr", 8'h10, 1'b0);
    tacho(8'h00); out_check("stall_z1b", 8'h14, 1'b0);
    tacho(8'h00); out_check("stall_z2b", 8'h18, 1'b0);
    tacho(8'h00); out_check("stall_entry", 8'hff, 1'b1);
    apply(1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    out_check("stall_irq_once", 8'hff, 1'b0);
    rd_check("stall_ctrl", 5'd0, 8'h83);

    apply(1'b1, 5'd0, 8'h83, 1'b0, 1'b0, 8'h00);
    out_check("stall_ack", 8'hff, 1'b0);
    rd_check("stall_ack_ctrl", 5'd0, 8'h03);
    for (int k = 0; k < 7; k++) apply(1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    tacho(8'hff); out_check("respin_still", 8'hff, 1'b0);
    apply(1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    tacho(8'hff); out_check("respin_regulate", 8'hfb, 1'b0);

    // TARGET write coincident with a sample: step uses the old TARGET (0x20).
    apply(1'b1, 5'd1, 8'h40, 1'b0, 1'b1, 8'h30);
    out_check("old_target_step", 8'hf7, 1'b0);
    rd_check("new_target", 5'd1, 8'h40);

    // Second stall, then clear EN: duty off but the flag remains.
    tacho(8'h00); out_check("stall2_z1", 8'hfb, 1'b0);
    tacho(8'h00); out_check("stall2_z2", 8'hff, 1'b0);
    tacho(8'h00); out_check("stall2_entry", 8'hff, 1'b1);
    apply(1'b1, 5'd0, 8'h02, 1'b0, 1'b0, 8'h00);
    out_check("stall_en_off", 8'h00, 1'b0);
    rd_check("stall_en_off_ctrl", 5'd0, 8'h82);

    // Asynchronous reset between clock edges.
    apply(1'b1, 5'd0, 8'h01, 1'b0, 1'b0, 8'h00);
    out_check("pre_reset_manual", 8'h80, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    out_check("async_reset", 8'h00, 1'b0);
    rd_check("async_reset_ctrl", 5'd0, 8'h00);
    rd_check("async_reset_man", 5'd2, 8'h00);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      logic       we, ce, tv;
      logic [4:0] a;
      logic [7:0] di, cnt;
      we  = ($urandom_range(0, 15) == 0);
      a   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(3, 31)) : 5'($urandom_range(0, 2));
      di  = 8'($urandom);
      if (a == 5'd0 && $urandom_range(0, 3) != 0) di[1:0] = 2'b11;
      ce  = 1'($urandom_range(0, 1));
      tv  = ($urandom_range(0, 2) == 0);
      cnt = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 80));
      apply(we, a, di, ce, tv, cnt);
      check($sformatf("rnd%0d_duty", i), 32'(duty), 32'(m_duty));
      check($sformatf("rnd%0d_irq", i), 32'(stall_irq), 32'(m_irq));
      a = 5'($urandom_range(0, 4));
      rd_check($sformatf("rnd%0d_rd", i), a, model_read(a));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
